// File: rtl/mem_axi_pkg.sv
// Shared encodings for the AXI read/write sequencers of mem_axi_arbiter.
package mem_axi_pkg;
  localparam logic [1:0] INCR  = 2'b01;
  localparam int         CNT_W = 8;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wr_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way read grant: dcache vs icache, round-robin or dcache-first.
module rr_arbiter2 #(
  parameter int RR_EN = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic req_d,
  input  logic req_i,
  input  logic take,
  output logic gnt_d,
  output logic gnt_any
);
  // 1 = dcache was granted last; reset favours dcache on the first tie
  logic last_d;

  assign gnt_any = req_d | req_i;

  always_comb begin
    gnt_d = req_d;
    if (req_d && req_i) gnt_d = (RR_EN != 0) ? !last_d : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn)                 last_d <= 1'b0;
    else if (take && gnt_any)  last_d <= gnt_d;
  end
endmodule

// File: rtl/mem_axi_arbiter.sv
// Shares one AXI4 master between icache reads and dcache reads/write-backs.
// Handshakes: a beat or address transfers on a cycle where valid && ready.
module mem_axi_arbiter
  import mem_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RR_EN      = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_rvalid,
  output logic                      i_rready,
  input  logic [ADDR_WIDTH-1:0]     i_raddr,
  input  logic [7:0]                i_rlen,
  input  logic [2:0]                i_rsize,
  output logic [DATA_WIDTH-1:0]     i_rdata,
  output logic                      i_rlast,
  input  logic                      d_rvalid,
  output logic                      d_rready,
  input  logic [ADDR_WIDTH-1:0]     d_raddr,
  input  logic [7:0]                d_rlen,
  input  logic [2:0]                d_rsize,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      d_rlast,
  input  logic                      d_wvalid,
  input  logic [ADDR_WIDTH-1:0]     d_waddr,
  input  logic [7:0]                d_wlen,
  input  logic [2:0]                d_wsize,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  input  logic [DATA_WIDTH/8-1:0]   d_wstrb,
  output logic                      d_wready,
  output logic                      d_bvalid,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [1:0]                rd_state_dbg,
  output logic [1:0]                wr_state_dbg
);
  rd_state_t         rd_state, rd_next;
  wr_state_t         wr_state, wr_next;
  logic              grant_d;
  logic              gnt_d, gnt_any;
  logic [CNT_W-1:0]  cnt;
  logic              unused_resp;

  assign unused_resp  = ^{rresp, bresp};
  assign arburst      = INCR;
  assign awburst      = INCR;
  assign rd_state_dbg = rd_state;
  assign wr_state_dbg = wr_state;

  // A dcache read waits for any outstanding write-back to finish
  rr_arbiter2 #(.RR_EN(RR_EN)) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req_d   (d_rvalid && (wr_state == W_IDLE)),
    .req_i   (i_rvalid),
    .take    (rd_state == R_IDLE),
    .gnt_d   (gnt_d),
    .gnt_any (gnt_any)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_state <= R_IDLE;
      grant_d  <= 1'b0;
      araddr   <= '0;
      arlen    <= '0;
      arsize   <= '0;
    end else begin
      rd_state <= rd_next;
      if (rd_state == R_IDLE && gnt_any) begin
        grant_d <= gnt_d;
        araddr  <= gnt_d ? d_raddr : i_raddr;
        arlen   <= gnt_d ? d_rlen  : i_rlen;
        arsize  <= gnt_d ? d_rsize : i_rsize;
      end
    end
  end

  always_comb begin
    rd_next  = rd_state;
    arvalid  = 1'b0;
    rready   = 1'b0;
    i_rready = 1'b0;
    i_rlast  = 1'b0;
    i_rdata  = '0;
    d_rready = 1'b0;
    d_rlast  = 1'b0;
    d_rdata  = '0;
    case (rd_state)
      R_IDLE: if (gnt_any) rd_next = R_AR;
      R_AR: begin
        arvalid = 1'b1;
        if (arready) rd_next = R_DATA;
      end
      R_DATA: begin
        rready  = 1'b1;
        i_rdata = rdata;
        d_rdata = rdata;
        if (grant_d) begin
          d_rready = rvalid;
          d_rlast  = rlast;
        end else begin
          i_rready = rvalid;
          i_rlast  = rlast;
        end
        if (rvalid && rlast) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_state <= W_IDLE;
      awaddr   <= '0;
      awlen    <= '0;
      awsize   <= '0;
      cnt      <= '0;
    end else begin
      wr_state <= wr_next;
      if (wr_state == W_IDLE && d_wvalid) begin
        awaddr <= d_waddr;
        awlen  <= d_wlen;
        awsize <= d_wsize;
        cnt    <= '0;
      end else if (wr_state == W_DATA && wready) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    wr_next  = wr_state;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    wdata    = '0;
    wstrb    = '0;
    wlast    = 1'b0;
    d_wready = 1'b0;
    bready   = 1'b0;
    d_bvalid = 1'b0;
    case (wr_state)
      W_IDLE: if (d_wvalid) wr_next = W_AW;
      W_AW: begin
        awvalid = 1'b1;
        if (awready) wr_next = W_DATA;
      end
      W_DATA: begin
        wvalid   = 1'b1;
        wdata    = d_wdata;
        wstrb    = d_wstrb;
        wlast    = (cnt == awlen);
        d_wready = wready;
        if (wready && wlast) wr_next = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          d_bvalid = 1'b1;
          wr_next  = W_IDLE;
        end
      end
      default: wr_next = W_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_axi_arbiter.sv
// Directed bench for mem_axi_arbiter: reads, round-robin, write-back ordering, backpressure, reset.
module tb_mem_axi_arbiter;
  logic        clk, rstn;
  logic        i_rvalid, i_rready, i_rlast;
  logic [31:0] i_raddr, i_rdata;
  logic [7:0]  i_rlen;
  logic [2:0]  i_rsize;
  logic        d_rvalid, d_rready, d_rlast;
  logic [31:0] d_raddr, d_rdata;
  logic [7:0]  d_rlen;
  logic [2:0]  d_rsize;
  logic        d_wvalid, d_wready, d_bvalid;
  logic [31:0] d_waddr, d_wdata;
  logic [7:0]  d_wlen;
  logic [2:0]  d_wsize;
  logic [3:0]  d_wstrb;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic [1:0]  rd_state_dbg, wr_state_dbg;
  int          total = 0;
  int          bad = 0;

  mem_axi_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_EN(1)) dut (
    .clk(clk), .rstn(rstn),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_raddr(i_raddr), .i_rlen(i_rlen),
    .i_rsize(i_rsize), .i_rdata(i_rdata), .i_rlast(i_rlast),
    .d_rvalid(d_rvalid), .d_rready(d_rready), .d_raddr(d_raddr), .d_rlen(d_rlen),
    .d_rsize(d_rsize), .d_rdata(d_rdata), .d_rlast(d_rlast),
    .d_wvalid(d_wvalid), .d_waddr(d_waddr), .d_wlen(d_wlen), .d_wsize(d_wsize),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wready(d_wready), .d_bvalid(d_bvalid),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks: called at posedge+1, drive, settle 1, sample
  task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len, input int delay);
    for (int k = 0; k <= delay; k++) begin
      arready = (k == delay);
      #1;
      check("arvalid", arvalid, 1);
      check("araddr", araddr, addr);
      check("arlen", arlen, len);
      check("arsize", arsize, 2);
      tick();
    end
    arready = 1'b0;
  endtask

  task automatic r_beats(input bit is_d, input int len, input logic [31:0] base);
    for (int b = 0; b <= len; b++) begin
      rvalid = 1'b1;
      rdata  = base + b;
      rlast  = (b == len);
      #1;
      check("rready", rready, 1);
      check("own_rready", is_d ? d_rready : i_rready, 1);
      check("other_rready", is_d ? i_rready : d_rready, 0);
      check("own_rdata", is_d ? d_rdata : i_rdata, base + b);
      check("own_rlast", is_d ? d_rlast : i_rlast, (b == len));
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rdata  = '0;
  endtask

  task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len, input int delay);
    for (int k = 0; k <= delay; k++) begin
      awready = (k == delay);
      #1;
      check("awvalid", awvalid, 1);
      check("awaddr", awaddr, addr);
      check("awlen", awlen, len);
      check("awburst", awburst, 1);
      tick();
    end
    awready = 1'b0;
  endtask

  task automatic w_beats(input int len, input bit toggle, input bit hold_rd);
    int b = 0;
    int cyc = 0;
    while (b <= len && cyc < 40) begin
      wready  = toggle ? cyc[0] : 1'b1;
      d_wdata = 32'hD000 + b;
      d_wstrb = b[0] ? 4'h3 : 4'hF;
      #1;
      check("wvalid", wvalid, 1);
      check("wdata", wdata, 32'hD000 + b);
      check("wstrb", wstrb, b[0] ? 4'h3 : 4'hF);
      check("wlast", wlast, (b == len));
      check("d_wready", d_wready, wready);
      if (hold_rd) check("raw_hold_ar", arvalid, 0);
      tick();
      if (wready) b++;
      cyc++;
    end
    check("w_beat_count", b, len + 1);
    wready = 1'b0;
  endtask

  task automatic b_phase(input int delay, input bit hold_rd);
    for (int k = 0; k <= delay; k++) begin
      bvalid = (k == delay);
      #1;
      check("wvalid_in_resp", wvalid, 0);
      check("bready", bready, 1);
      check("d_bvalid", d_bvalid, (k == delay));
      if (hold_rd) check("raw_hold_b", arvalid, 0);
      tick();
    end
    bvalid = 1'b0;
    #1;
    check("d_bvalid_pulse", d_bvalid, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_arvalid"}, arvalid, 0);
    check({tag, "_araddr"}, araddr, 0);
    check({tag, "_arlen"}, arlen, 0);
    check({tag, "_arburst"}, arburst, 1);
    check({tag, "_rready"}, rready, 0);
    check({tag, "_i_rready"}, i_rready, 0);
    check({tag, "_i_rdata"}, i_rdata, 0);
    check({tag, "_d_rready"}, d_rready, 0);
    check({tag, "_awvalid"}, awvalid, 0);
    check({tag, "_awaddr"}, awaddr, 0);
    check({tag, "_awburst"}, awburst, 1);
    check({tag, "_wvalid"}, wvalid, 0);
    check({tag, "_wlast"}, wlast, 0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_bready"}, bready, 0);
    check({tag, "_d_bvalid"}, d_bvalid, 0);
    check({tag, "_rd_state"}, rd_state_dbg, 0);
    check({tag, "_wr_state"}, wr_state_dbg, 0);
  endtask

  initial begin
    rstn = 1'b0;
    i_rvalid = 0; i_raddr = 0; i_rlen = 0; i_rsize = 3'd2;
    d_rvalid = 0; d_raddr = 0; d_rlen = 0; d_rsize = 3'd2;
    d_wvalid = 0; d_waddr = 0; d_wlen = 0; d_wsize = 3'd2; d_wdata = 0; d_wstrb = 0;
    arready = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
    repeat (3) tick();
    #1;
    check_idle_outputs("reset");
    rstn = 1'b1;
    tick();

    // icache alone
    i_raddr = 32'h0000_1040; i_rlen = 8'd3; i_rvalid = 1'b1;
    tick();
    ar_phase(32'h1040, 3, 0);
    r_beats(1'b0, 3, 32'hA0);
    i_rvalid = 1'b0;
    #1;
    check("i_done_idle", rd_state_dbg, 0);
    tick();

    // simultaneous requests, round-robin: d, i, d, i
    for (int rep = 0; rep < 2; rep++) begin
      d_raddr = 32'h3000 + rep * 32'h100; d_rlen = 8'd1;
      i_raddr = 32'h1000 + rep * 32'h100; i_rlen = 8'd1;
      d_rvalid = 1'b1; i_rvalid = 1'b1;
      tick();
      ar_phase(32'h3000 + rep * 32'h100, 1, 0);
      r_beats(1'b1, 1, 32'h30 + rep * 16);
      d_rvalid = 1'b0;
      #1;
      check("rr_gap", arvalid, 0);
      tick();
      ar_phase(32'h1000 + rep * 32'h100, 1, 0);
      r_beats(1'b0, 1, 32'h10 + rep * 16);
      i_rvalid = 1'b0;
      tick();
    end

    // write-back with a dcache read held off until d_bvalid
    d_waddr = 32'h2000; d_wlen = 8'd3; d_wvalid = 1'b1;
    tick();
    aw_phase(32'h2000, 3, 0);
    d_raddr = 32'h5000; d_rlen = 8'd0; d_rvalid = 1'b1;
    w_beats(3, 1'b0, 1'b1);
    b_phase(2, 1'b1);
    d_wvalid = 1'b0;
    #1;
    check("raw_after_b", arvalid, 0);
    tick();
    ar_phase(32'h5000, 0, 0);
    r_beats(1'b1, 0, 32'h50);
    d_rvalid = 1'b0;
    tick();

    // concurrent icache read and dcache write
    i_raddr = 32'h1100; i_rlen = 8'd1; i_rvalid = 1'b1;
    d_waddr = 32'h2200; d_wlen = 8'd1; d_wvalid = 1'b1;
    tick();
    arready = 1'b1; awready = 1'b1;
    #1;
    check("conc_arvalid", arvalid, 1);
    check("conc_awvalid", awvalid, 1);
    check("conc_araddr", araddr, 32'h1100);
    check("conc_awaddr", awaddr, 32'h2200);
    tick();
    arready = 1'b0; awready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1; rdata = 32'hB0 + b; rlast = (b == 1);
      wready = 1'b1; d_wdata = 32'hE0 + b; d_wstrb = 4'hF;
      #1;
      check("conc_i_rready", i_rready, 1);
      check("conc_d_rready", d_rready, 0);
      check("conc_i_rdata", i_rdata, 32'hB0 + b);
      check("conc_i_rlast", i_rlast, (b == 1));
      check("conc_wvalid", wvalid, 1);
      check("conc_wdata", wdata, 32'hE0 + b);
      check("conc_wlast", wlast, (b == 1));
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; wready = 1'b0; i_rvalid = 1'b0;
    b_phase(0, 1'b0);
    d_wvalid = 1'b0;
    tick();

    // backpressure: arready late, wready toggling
    i_raddr = 32'h1200; i_rlen = 8'd1; i_rvalid = 1'b1;
    tick();
    ar_phase(32'h1200, 1, 5);
    r_beats(1'b0, 1, 32'hC0);
    i_rvalid = 1'b0;
    d_waddr = 32'h2300; d_wlen = 8'd2; d_wvalid = 1'b1;
    tick();
    aw_phase(32'h2300, 2, 3);
    w_beats(2, 1'b1, 1'b0);
    b_phase(1, 1'b0);
    d_wvalid = 1'b0;
    tick();

    // reset mid-burst
    i_raddr = 32'h1300; i_rlen = 8'd3; i_rvalid = 1'b1;
    d_waddr = 32'h2400; d_wlen = 8'd3; d_wvalid = 1'b1;
    tick();
    arready = 1'b1; awready = 1'b1;
    tick();
    arready = 1'b0; awready = 1'b0;
    rvalid = 1'b1; rdata = 32'h77; wready = 1'b1; d_wdata = 32'h88;
    tick();
    rstn = 1'b0;
    tick();
    #1;
    check_idle_outputs("midrst");
    rstn = 1'b1; rvalid = 1'b0; wready = 1'b0; i_rvalid = 1'b0; d_wvalid = 1'b0;
    tick();

    // post-reset read and single-beat write
    d_raddr = 32'h6000; d_rlen = 8'd1; d_rvalid = 1'b1;
    tick();
    ar_phase(32'h6000, 1, 0);
    r_beats(1'b1, 1, 32'h60);
    d_rvalid = 1'b0;
    d_waddr = 32'h2500; d_wlen = 8'd0; d_wvalid = 1'b1;
    tick();
    aw_phase(32'h2500, 0, 0);
    w_beats(0, 1'b0, 1'b0);
    b_phase(0, 1'b0);
    d_wvalid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
